// File: rtl/mux_arbiter8.sv
// mux_arbiter8: round-robin 8:1 mux path arbiter with forced release after MAX_HOLD cycles
module mux_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       valid,
  output logic       timeout
);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state;
  logic [2:0] ptr, pick;
  logic [7:0] hold_cnt;
  logic hold_max, rel;
  always_comb begin
    pick = ptr;
    for (int i = 7; i >= 0; i--) pick = req[ptr + 3'(i)] ? ptr + 3'(i) : pick;
  end
  assign hold_max = hold_cnt == 8'(MAX_HOLD);
  assign rel = done | ~req[sel] | hold_max;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 8'h00;
      sel      <= 3'd0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= 3'd0;
      hold_cnt <= 8'd0;
    end else if (state == IDLE) begin
      timeout <= 1'b0;
      if (|req) begin
        state    <= OWN;
        grant    <= 8'd1 << pick;
        sel      <= pick;
        valid    <= 1'b1;
        hold_cnt <= 8'd1;
      end
    end else if (rel) begin
      state    <= IDLE;
      grant    <= 8'h00;
      valid    <= 1'b0;
      ptr      <= sel + 3'd1;
      hold_cnt <= 8'd0;
      timeout  <= hold_max & ~done & req[sel];
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_mux_arbiter8.sv
// tb_mux_arbiter8: directed scoreboard bench for mux_arbiter8 with per-cycle invariant checks
module tb_mux_arbiter8;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid, timeout;
  int total = 0;
  int bad = 0;
  logic run = 1'b1;
  logic [2:0] last_sel = 3'd0;
  typedef struct packed {
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    logic       t;
  } exp_t;
  exp_t sb[$];
  mux_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .sel(sel), .valid(valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rs, input logic [7:0] r, input logic d, input logic [7:0] eg, input logic et);
    exp_t e;
    logic [2:0] es;
    es = rs ? 3'd0 : last_sel;
    for (int i = 0; i < 8; i++) if (eg[i]) es = 3'(i);
    last_sel = es;
    e = '{g: eg, s: es, v: |eg, t: et};
    sb.push_back(e);
    reset = rs;
    req = r;
    done = d;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("grant", 32'(grant), 32'(e.g));
    chk("sel", 32'(sel), 32'(e.s));
    chk("valid", 32'(valid), 32'(e.v));
    chk("timeout", 32'(timeout), 32'(e.t));
  endtask
  always @(negedge clk) begin
    if (run) begin
      chk("onehot0", 32'($onehot0(grant)), 32'd1);
      chk("valid_or", 32'(valid), 32'(|grant));
      if (valid) chk("sel_idx", 32'(grant[sel]), 32'd1);
    end
  end
  initial begin
    step(1, 8'h00, 0, 8'h00, 0);
    step(0, 8'h04, 0, 8'h04, 0);
    step(0, 8'h04, 1, 8'h00, 0);
    step(0, 8'h0D, 0, 8'h08, 0);
    step(0, 8'h00, 1, 8'h00, 0);
    step(0, 8'h00, 0, 8'h00, 0);
    step(0, 8'h00, 1, 8'h00, 0);
    step(1, 8'h00, 0, 8'h00, 0);
    for (int k = 0; k < 9; k++) begin
      step(0, 8'hFF, 0, 8'd1 << (k % 8), 0);
      step(0, 8'hFF, 1, 8'h00, 0);
    end
    step(1, 8'h00, 0, 8'h00, 0);
    for (int k = 0; k < 4; k++) step(0, 8'h03, 0, 8'h01, 0);
    step(0, 8'h03, 0, 8'h00, 1);
    step(0, 8'h03, 0, 8'h02, 0);
    step(0, 8'h03, 1, 8'h00, 0);
    for (int k = 0; k < 4; k++) step(0, 8'h03, 0, 8'h01, 0);
    step(0, 8'h03, 1, 8'h00, 0);
    step(1, 8'h00, 0, 8'h00, 0);
    step(0, 8'h20, 0, 8'h20, 0);
    step(0, 8'h84, 1, 8'h00, 0);
    step(0, 8'h84, 0, 8'h80, 0);
    step(0, 8'h81, 0, 8'h80, 0);
    step(0, 8'h04, 0, 8'h00, 0);
    step(0, 8'hC4, 0, 8'h04, 0);
    step(1, 8'h00, 0, 8'h00, 0);
    for (int k = 0; k < 3; k++) step(0, 8'h10, 0, 8'h10, 0);
    step(1, 8'h10, 0, 8'h00, 0);
    step(0, 8'h90, 0, 8'h10, 0);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_arbiter8.md
MUX_ARBITER8 -- requirements
Module: mux_arbiter8

Interface
REQ-001 Parameter: MAX_HOLD, 16, maximum consecutive grant cycles per owner before forced release; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  8  request vector; bit i = requester i wants the shared 8:1 mux path.
REQ-005 Port: done  input  1  current owner releases the path; ignored when no grant is active.
REQ-006 Port: grant  output  8  registered grant; at most one bit high.
REQ-007 Port: sel  output  3  registered mux select; equals the index of the granted bit and drives the 8:1 mux select line.
REQ-008 Port: valid  output  1  high exactly when any grant bit is high.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-010 The block SHALL implement two states, IDLE (no grant) and OWN (one grant held).
REQ-011 In IDLE with req != 0, the block SHALL select the first set req bit at or after index ptr, searching upward with wrap 7->0.
REQ-012 The selection SHALL enter OWN at the next edge, setting grant, sel and valid together: one cycle from req sampled to grant visible.
REQ-013 In IDLE with req == 0, the block SHALL remain in IDLE with grant=0 and valid=0.
REQ-014 sel SHALL hold its last value while in IDLE.
REQ-015 In OWN, hold_cnt SHALL count granted cycles: 1 in the first grant cycle, incrementing each cycle, saturating at MAX_HOLD.
REQ-016 In OWN, release SHALL occur at the next edge when any of the following holds:
- done=1;
- req[owner]=0;
- hold_cnt==MAX_HOLD.
REQ-017 On release, the block SHALL go to IDLE, clear grant and valid, and set ptr=(owner+1) mod 8, with 7 wrapping to 0.
REQ-018 Release SHALL force exactly one IDLE cycle (grant=0) before any new grant, even if req is still nonzero (bus turnaround).
REQ-019 timeout SHALL pulse high for the single cycle following a release caused only by hold_cnt==MAX_HOLD, i.e. with done=0 and req[owner]=1.
- Simultaneous done and timeout SHALL count as a normal release with timeout=0.
REQ-020 Simultaneous done=1 and req[owner]=0 SHALL produce a single release.
REQ-021 done=1 in IDLE SHALL have no effect.
REQ-022 Changes to req bits other than the owner's during OWN SHALL NOT affect the current grant.
REQ-023 A requester that is force-released and keeps requesting SHALL be served only after every other active requester has been served once (round-robin fairness).
REQ-024 grant SHALL never have more than one bit set, and valid SHALL equal |grant in every cycle.

Reset
REQ-025 When reset=1 at an edge, the block SHALL set:
- state=IDLE, grant=8'h00, sel=3'd0, valid=0, timeout=0;
- ptr=0, hold_cnt=0.
REQ-026 Reset during OWN SHALL drop the grant at that edge without asserting timeout.
REQ-027 The first arbitration after reset SHALL start searching at index 0.

Verification
REQ-028 The bench SHALL cover, at minimum, the following directed scenarios:
- Basic grant: after reset, req=8'b0000_0100 -> next cycle grant=8'h04, sel=2, valid=1. Then done=1 for one cycle -> grant=0 the next cycle, ptr=3.
- Round-robin with wrap: req=8'hFF held, done pulsed in each grant's final cycle. Grant order SHALL be 0,1,2,...,7,0, with one grant=0 gap cycle between consecutive grants.
- Timeout: MAX_HOLD=4, req=8'b0000_0011 held, done=0. grant=8'h01 for exactly 4 cycles, then timeout=1 with grant=0, then grant=8'h02.
- Owner drop and simultaneous release: owner 5 granted; req[5] falls in the same cycle done=1. Exactly one release, timeout=0, ptr=6, next grant goes to the lowest set req bit at or after 6 (wrapping).
- Reset mid-grant: grant=8'h10 with hold_cnt=3, reset=1 for one cycle. Next cycle grant=0, sel=0, timeout=0. With req=8'h90 afterwards, the first grant SHALL be 8'h10 (search from 0).
- Invariant check, every cycle: $onehot0(grant) and valid==|grant. sel equals the index of the grant bit whenever valid=1.
